// File: rtl/inert_pkg.sv
// Shared types and SPI command words for the inertial sensor sequencer.
`timescale 1ns/1ps
package inert_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    CFG1,
    CFG2,
    CFG3,
    WAIT_INT,
    RD_L,
    RD_H
  } state_t;

  // Sub-state inside each SPI state: first cycle issues wrt, then waits on done.
  typedef enum logic {
    PH_WAIT  = 1'b0,
    PH_ISSUE = 1'b1
  } phase_t;

  localparam logic [15:0] CMD_CFG1 = 16'h0D02;
  localparam logic [15:0] CMD_CFG2 = 16'h1160;
  localparam logic [15:0] CMD_CFG3 = 16'h1440;
  localparam logic [15:0] CMD_YAWL = 16'hA600;
  localparam logic [15:0] CMD_YAWH = 16'hA700;

endpackage

// File: rtl/inert_seq.sv
// Inertial sensor sequencer: power-up wait, three config writes, then yaw-rate
// reads (low byte, high byte) on every synchronized data-ready from the sensor.
`timescale 1ns/1ps
module inert_seq
  import inert_pkg::*;
#(
  parameter int unsigned TMR_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        rdy
);

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             int_ff1_q, int_s_q;
  logic             done_q;
  logic             rdy_q, rdy_d;
  logic             vld_q, vld_d;
  logic [15:0]      yaw_q, yaw_d;
  logic [7:0]       yaw_lo_q, yaw_lo_d;
  logic             done_rise;
  logic             resp;
  logic             rd_hi_unused;

  // Only the low byte of each SPI read carries yaw data.
  assign rd_hi_unused = ^rd_data[15:8];

  assign done_rise = done & ~done_q;
  // A completion only counts once the issue cycle is over.
  assign resp      = (phase_q == PH_WAIT) & done_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PWR_WAIT;
      phase_q   <= PH_WAIT;
      tmr_q     <= '0;
      int_ff1_q <= 1'b0;
      int_s_q   <= 1'b0;
      done_q    <= 1'b0;
      rdy_q     <= 1'b0;
      vld_q     <= 1'b0;
      yaw_q     <= '0;
      yaw_lo_q  <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      tmr_q     <= tmr_d;
      int_ff1_q <= INT;
      int_s_q   <= int_ff1_q;
      done_q    <= done;
      rdy_q     <= rdy_d;
      vld_q     <= vld_d;
      yaw_q     <= yaw_d;
      yaw_lo_q  <= yaw_lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = PH_WAIT;
    tmr_d    = tmr_q;
    rdy_d    = rdy_q;
    vld_d    = 1'b0;
    yaw_d    = yaw_q;
    yaw_lo_d = yaw_lo_q;
    wrt      = 1'b0;
    cmd      = '0;
    case (state_q)
      PWR_WAIT: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (&tmr_q) begin
          state_d = CFG1;
          phase_d = PH_ISSUE;
        end
      end
      CFG1: begin
        cmd = CMD_CFG1;
        wrt = (phase_q == PH_ISSUE);
        if (resp) begin
          state_d = CFG2;
          phase_d = PH_ISSUE;
        end
      end
      CFG2: begin
        cmd = CMD_CFG2;
        wrt = (phase_q == PH_ISSUE);
        if (resp) begin
          state_d = CFG3;
          phase_d = PH_ISSUE;
        end
      end
      CFG3: begin
        cmd = CMD_CFG3;
        wrt = (phase_q == PH_ISSUE);
        if (resp) begin
          state_d = WAIT_INT;
          rdy_d   = 1'b1;
        end
      end
      WAIT_INT: begin
        if (int_s_q) begin
          state_d = RD_L;
          phase_d = PH_ISSUE;
        end
      end
      RD_L: begin
        cmd = CMD_YAWL;
        wrt = (phase_q == PH_ISSUE);
        if (resp) begin
          yaw_lo_d = rd_data[7:0];
          state_d  = RD_H;
          phase_d  = PH_ISSUE;
        end
      end
      RD_H: begin
        cmd = CMD_YAWH;
        wrt = (phase_q == PH_ISSUE);
        if (resp) begin
          yaw_d   = {rd_data[7:0], yaw_lo_q};
          vld_d   = 1'b1;
          state_d = WAIT_INT;
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  assign yaw_rt = yaw_q;
  assign vld    = vld_q;
  assign rdy    = rdy_q;

endmodule

// File: tb/tb_inert_seq.sv
// Scoreboard bench for inert_seq with a behavioural SPI monarch model.
`timescale 1ns/1ps
module tb_inert_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt, vld, rdy;
  logic [15:0] cmd, yaw_rt;

  int n_checks = 0;
  int n_fail   = 0;
  int wrt_cnt  = 0;
  int stale_hold = 0;

  logic [15:0] exp_cmd_q[$];
  logic [15:0] exp_yaw_q[$];
  logic [15:0] rd_q[$];

  inert_seq #(.TMR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .yaw_rt(yaw_rt), .vld(vld), .rdy(rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // SPI monarch model: done clears after a wrt (optionally held stale for a
  // few cycles) and rises 40 clocks after the wrt.
  initial begin
    int cnt;
    int clr;
    bit busy;
    logic [15:0] pend;
    logic        nd;
    logic [15:0] nr;
    cnt = 0; clr = -1; busy = 0; pend = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0; clr = -1;
        rd_q.delete();
        #1 done = 1'b0;
        continue;
      end
      nd = done; nr = rd_data;
      if (wrt) begin
        busy = 1; cnt = 40; pend = cmd; clr = stale_hold;
      end else if (busy) cnt--;
      if (clr == 0) nd = 1'b0;
      if (clr >= 0) clr--;
      if (busy && cnt == 0) begin
        busy = 0;
        nd = 1'b1;
        if (pend == 16'hA600 || pend == 16'hA700)
          nr = (rd_q.size() > 0) ? rd_q.pop_front() : 16'hDEAD;
        else
          nr = 16'h0000;
      end
      #1 done = nd; rd_data = nr;
    end
  end

  // Monitor: every wrt and every vld is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (wrt) begin
        wrt_cnt++;
        if (exp_cmd_q.size() == 0) check("unexpected_wrt", int'(cmd), 32'h7FFF_FFFF);
        else check("wrt_cmd", int'(cmd), int'(exp_cmd_q.pop_front()));
      end
      if (vld) begin
        if (exp_yaw_q.size() == 0) check("unexpected_vld", int'(yaw_rt), 32'h7FFF_FFFF);
        else check("yaw_rt", int'(yaw_rt), int'(exp_yaw_q.pop_front()));
      end
    end
  end

  task automatic wait_wrt(input logic [15:0] c, input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); @(negedge clk);
      if (wrt && cmd == c) begin cyc = i; break; end
    end
    if (cyc < 0) check("timeout_wrt", 0, int'(c));
  endtask

  task automatic wait_vld(input int limit);
    bit seen;
    seen = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); @(negedge clk);
      if (vld) begin seen = 1; break; end
    end
    if (!seen) check("timeout_vld", 0, 1);
  endtask

  task automatic wait_rdy(input int limit);
    bit seen;
    seen = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); @(negedge clk);
      if (rdy) begin seen = 1; break; end
    end
    if (!seen) check("timeout_rdy", 0, 1);
  endtask

  task automatic power_up(input string tag);
    int c;
    exp_cmd_q.push_back(16'h0D02);
    exp_cmd_q.push_back(16'h1160);
    exp_cmd_q.push_back(16'h1440);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); @(negedge clk); end
    check({tag, "_pwr_cmd_zero"}, int'(cmd), 0);
    wait_wrt(16'h0D02, 50, c);
    check({tag, "_first_wrt_latency"}, 8 + c, 16);
  endtask

  initial begin
    int c;
    int base;
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_wrt", int'(wrt), 0);
    check("rst_vld", int'(vld), 0);
    check("rst_rdy", int'(rdy), 0);
    check("rst_yaw", int'(yaw_rt), 0);
    check("rst_cmd", int'(cmd), 0);

    // Power-up and configuration; INT pulse during CFG2 must not start a read.
    power_up("boot");
    wait_wrt(16'h1160, 200, c);
    INT = 1'b1;
    repeat (5) @(negedge clk);
    INT = 1'b0;
    wait_rdy(300);
    check("rdy_after_three_cfg", wrt_cnt, 3);
    base = wrt_cnt;
    repeat (20) @(negedge clk);
    check("idle_no_read", wrt_cnt, base);
    check("idle_cmd_zero", int'(cmd), 0);

    // Single sample: INT edge to RD_L wrt is three clocks.
    exp_cmd_q.push_back(16'hA600);
    exp_cmd_q.push_back(16'hA700);
    rd_q.push_back(16'h0034);
    rd_q.push_back(16'h0012);
    exp_yaw_q.push_back(16'h1234);
    @(negedge clk);
    INT = 1'b1;
    wait_wrt(16'hA600, 20, c);
    check("int_to_wrt_latency", c, 3);
    wait_wrt(16'hA700, 200, c);
    INT = 1'b0;
    wait_vld(200);
    repeat (10) @(negedge clk);
    check("single_read_yaw_hold", int'(yaw_rt), 16'h1234);

    // Back-to-back samples with done held stale after each wrt.
    stale_hold = 5;
    exp_cmd_q.push_back(16'hA600);
    exp_cmd_q.push_back(16'hA700);
    exp_cmd_q.push_back(16'hA600);
    exp_cmd_q.push_back(16'hA700);
    rd_q.push_back(16'h00FF);
    rd_q.push_back(16'h0080);
    rd_q.push_back(16'h0001);
    rd_q.push_back(16'h0000);
    exp_yaw_q.push_back(16'h80FF);
    exp_yaw_q.push_back(16'h0001);
    base = wrt_cnt;
    INT = 1'b1;
    wait_wrt(16'hA700, 200, c);
    wait_wrt(16'hA700, 200, c);
    INT = 1'b0;
    wait_vld(200);
    repeat (10) @(negedge clk);
    check("b2b_wrt_count", wrt_cnt - base, 4);
    stale_hold = 0;

    // Reset while RD_H waits, then full restart.
    exp_cmd_q.push_back(16'hA600);
    exp_cmd_q.push_back(16'hA700);
    rd_q.push_back(16'h0011);
    rd_q.push_back(16'h0022);
    INT = 1'b1;
    wait_wrt(16'hA700, 200, c);
    repeat (10) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_wrt", int'(wrt), 0);
    check("midrst_vld", int'(vld), 0);
    check("midrst_rdy", int'(rdy), 0);
    check("midrst_yaw", int'(yaw_rt), 0);
    check("midrst_cmd", int'(cmd), 0);
    INT = 1'b0;
    repeat (3) @(negedge clk);
    power_up("restart");
    wait_rdy(300);
    repeat (10) @(negedge clk);
    check("cmd_queue_drained", exp_cmd_q.size(), 0);
    check("yaw_queue_drained", exp_yaw_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inert_seq.md
INERT_SEQ -- requirements
Module: inert_seq

Interface
REQ-001 Parameter TMR_W, default 16, width of the power-up wait timer (benches use 4).
REQ-002 clk  input  1  system clock, all flops rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 INT  input  1  sensor data-ready, asynchronous to clk, level, held high until data read.
REQ-005 done  input  1  SPI monarch transaction complete, level, cleared by the monarch on its next wrt.
REQ-006 rd_data  input  16  SPI monarch read word, valid when done high.
REQ-007 wrt  output  1  one-cycle pulse starting an SPI transaction.
REQ-008 cmd  output  16  SPI command word, stable from the wrt cycle until done rises.
REQ-009 yaw_rt  output  16  assembled yaw-rate sample, {high byte, low byte}.
REQ-010 vld  output  1  one-cycle pulse: yaw_rt updated this cycle.
REQ-011 rdy  output  1  configuration complete, high from end of CFG3 until reset.

Function
REQ-012 INT passes through a 2-flop synchronizer; only the synchronized INT_s is used.
REQ-013 Transaction completion is done_rise = done & ~done_q (done_q registered done); done level is never used directly.
REQ-014 States: PWR_WAIT, CFG1, CFG2, CFG3, WAIT_INT, RD_L, RD_H; each SPI state has an issue cycle and a wait sub-state (ISSUE/WAIT flag).
REQ-015 PWR_WAIT: TMR_W-bit timer counts up from 0 each clock; at all-ones, go to CFG1.
REQ-016 CFG1 cmd = 16'h0D02; CFG2 cmd = 16'h1160; CFG3 cmd = 16'h1440.
REQ-017 On entering an SPI state, wrt=1 for exactly one cycle; the state then holds until done_rise, then advances.
REQ-018 CFG1->CFG2->CFG3->WAIT_INT; rdy set on the CFG3 done_rise cycle.
REQ-019 WAIT_INT: if INT_s high, go to RD_L; otherwise hold; wrt=0.
REQ-020 RD_L cmd = 16'hA600; on done_rise latch rd_data[7:0] into yaw_lo, go to RD_H.
REQ-021 RD_H cmd = 16'hA700; on done_rise yaw_rt <= {rd_data[7:0], yaw_lo} and vld=1 for that cycle, go to WAIT_INT.
REQ-022 Sample latency: INT edge to wrt of RD_L is 3 clocks (2 sync + 1 state).
REQ-023 INT_s high on return to WAIT_INT starts another read immediately (back-to-back samples allowed).
REQ-024 INT activity before rdy is ignored; no read begins before CFG3 completes.
REQ-025 done_rise outside a wait sub-state is ignored; wrt is never reissued while waiting.
REQ-026 cmd equals 16'h0000 in PWR_WAIT and WAIT_INT.

Reset
REQ-027 Asynchronous reset: state=PWR_WAIT, timer=0, wrt=0, vld=0, rdy=0, yaw_rt=0, yaw_lo=0, sync flops=0, done_q=0.
REQ-028 Reset mid-transaction abandons it; after release the full power-up wait and configuration repeat.

Structure
REQ-029 Package inert_pkg holds state_t enum and the five command constants CMD_CFG1..CMD_CFG3, CMD_YAWL, CMD_YAWH.
REQ-030 inert_seq is a single module with no sub-modules; it connects directly to an SPI_mnrch instance at integration level.

Verification
REQ-031 TMR_W=4, reset released, SPI model returns done 40 clocks after wrt -> first wrt 16 clocks after release with cmd=0x0D02, then 0x1160, 0x1440; rdy rises after third done.
REQ-032 After rdy, INT high, model returns 0x0034 for A600 and 0x0012 for A700 -> one vld pulse, yaw_rt=0x1234.
REQ-033 INT held high across two reads, data 0x00FF/0x0080 then 0x0001/0x0000 -> two vld pulses, yaw_rt 0x80FF then 0x0001.
REQ-034 INT pulsed high during CFG2 -> no A600 command before rdy; read begins only if INT high after rdy.
REQ-035 Stale done held high from previous transaction at wrt -> controller waits for the next done rising edge, exactly one wrt per state.
REQ-036 rst_n asserted while RD_H waits -> all outputs zero immediately; after release, sequence restarts with PWR_WAIT and cmd 0x0D02.
